// File: rtl/parity_share_ctrl.sv
// parity_share_ctrl: round-robin arbiter in front of one shared bit-serial parity engine.
//
// The engine folds two data bits per cycle into a one-bit accumulator (acc ^ b0 ^ b1).
// Only one word is in flight at a time. The result is held until the consumer takes it.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   req_valid     per-requester word valid
//   req_ready     per-requester accept, one-hot or zero, only while idle
//   req_data      word i at [i*DATA_W +: DATA_W]
//   req_par       expected parity bit per requester
//   odd_mode      1 = odd parity, 0 = even; captured with the word
//   res_valid     result valid; res_ready is the consumer accept
//   res_id        requester index the result belongs to
//   res_par       generated parity bit
//   res_err       generated parity differs from the captured expected bit
//   busy          controller not idle
//   err_count     saturating count of accepted error results
//                 (only when PARITY_ERR_CNT_EN is defined)
module parity_share_ctrl #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req_valid,
  output logic [NUM_REQ-1:0]                       req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]                req_data,
  input  logic [NUM_REQ-1:0]                       req_par,
  input  logic                                     odd_mode,
  output logic                                     res_valid,
  input  logic                                     res_ready,
  output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] res_id,
  output logic                                     res_par,
  output logic                                     res_err,
  output logic                                     busy
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]                     err_count
`endif
);

  localparam int unsigned IdW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned Pairs = DATA_W / 2;
  localparam int unsigned CntW  = $clog2(Pairs) + 1;

  if (NUM_REQ < 2) begin : g_chk_num_req
    $error("NUM_REQ must be at least 2");
  end
  if (DATA_W < 2 || (DATA_W % 2) != 0) begin : g_chk_data_w
    $error("DATA_W must be even and at least 2");
  end
  if (ERR_CNT_W < 1) begin : g_chk_err_cnt_w
    $error("ERR_CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StShift, StResult} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                acc_q, acc_d;
  logic                par_q, par_d;
  logic                odd_q, odd_d;
  logic [IdW-1:0]      id_q, id_d;
  logic [IdW-1:0]      rr_q, rr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                win_found;
  logic [IdW-1:0]      win_id;
  logic [IdW-1:0]      idx;
  logic                transfer;

  // First valid requester starting at the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IdW'((32'(rr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // No grant while reset is held, so nothing looks accepted during reset.
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && win_found && !rst) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign transfer = |req_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    acc_d   = acc_q;
    par_d   = par_q;
    odd_d   = odd_q;
    id_d    = id_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          data_d  = req_data[32'(win_id)*DATA_W +: DATA_W];
          par_d   = req_par[win_id];
          odd_d   = odd_mode;
          id_d    = win_id;
          acc_d   = 1'b0;
          cnt_d   = '0;
          rr_d    = (win_id == IdW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        // Consume the lowest pair, then shift the next pair down.
        acc_d  = acc_q ^ data_q[0] ^ data_q[1];
        data_d = data_q >> 2;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(Pairs - 1)) begin
          state_d = StResult;
        end
      end
      StResult: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      acc_q   <= 1'b0;
      par_q   <= 1'b0;
      odd_q   <= 1'b0;
      id_q    <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      par_q   <= par_d;
      odd_q   <= odd_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    res_valid = (state_q == StResult);
    res_par   = res_valid & (acc_q ^ odd_q);
    res_err   = res_valid & (acc_q ^ odd_q ^ par_q);
    res_id    = res_valid ? id_q : '0;
    busy      = (state_q != StIdle);
  end

`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (res_valid && res_ready && res_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_share_ctrl.sv
// Self-checking bench for parity_share_ctrl (NUM_REQ=4, DATA_W=8).
// Expected grants, latencies and parity come from a small round-robin / popcount model.
module tb_parity_share_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int EW = 8;
  localparam int IW = 2;
  localparam int LAT = W / 2 + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     req_par = '0;
  logic             odd_mode = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [IW-1:0]    res_id;
  logic             res_par;
  logic             res_err;
  logic             busy;
`ifdef PARITY_ERR_CNT_EN
  logic [EW-1:0]    err_count;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rr       = 0;

  parity_share_ctrl #(
    .NUM_REQ   (N),
    .DATA_W    (W),
    .ERR_CNT_W (EW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_par   (req_par),
    .odd_mode  (odd_mode),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_par   (res_par),
    .res_err   (res_err),
    .busy      (busy)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: first valid index at or after pointer p, cyclically.
  function automatic int exp_winner(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic exp_par(input logic [W-1:0] d, input logic o);
    int ones = 0;
    for (int b = 0; b < W; b++) ones += int'(d[b]);
    return logic'(ones % 2) ^ o;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic wait_grant(input int budget, output logic [N-1:0] rdy, output int at);
    bit done = 0;
    rdy = '0;
    at  = -1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        rdy  = req_ready;
        at   = cyc;
        done = 1;
      end
    end
  endtask

  task automatic wait_result(input int budget, output int at);
    bit done = 0;
    at = -1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        at   = cyc;
        done = 1;
      end
    end
  endtask

  task automatic drain(output bit ok);
    ok        = 0;
    req_valid = '0;
    res_ready = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rr  = 0;
  endtask

  task automatic test_reset();
    bit ok;
    req_valid = 4'b1111;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || res_valid !== 1'b0 || busy !== 1'b0 || res_par !== 1'b0 ||
        res_err !== 1'b0 || res_id !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b v=%b busy=%b par=%b err=%b id=%0d, want all 0",
               req_ready, res_valid, busy, res_par, res_err, res_id);
    end
`ifdef PARITY_ERR_CNT_EN
    checks++;
    if (err_count !== '0) begin
      failures++;
      $display("FAIL reset_err_count: got %0d want 0", err_count);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    rr  = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== onehot(exp_winner(req_valid, rr))) begin
      failures++;
      $display("FAIL reset_first_grant: got %b want %b", req_ready,
               onehot(exp_winner(req_valid, rr)));
    end
    rr = 1;
    @(posedge clk);
    #1;
    drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_drain: busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic(input logic [W-1:0] d, input logic p, input logic o,
                            input logic want_par, input logic want_err, input string nm);
    logic [N-1:0] rdy;
    int tg, tr, ew;
    res_ready = 1'b1;
    odd_mode  = o;
    req_data  = '0;
    req_data[0 +: W] = d;
    req_par   = {3'b000, p};
    req_valid = 4'b0001;
    ew = exp_winner(req_valid, rr);
    wait_grant(20, rdy, tg);
    checks++;
    if (rdy !== onehot(ew)) begin
      failures++;
      $display("FAIL %s_grant: got %b want %b", nm, rdy, onehot(ew));
    end
    rr = (ew + 1) % N;
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_result(20, tr);
    checks++;
    if (tr != tg + LAT) begin
      failures++;
      $display("FAIL %s_latency: got cycle %0d want %0d", nm, tr, tg + LAT);
    end
    checks++;
    if (res_id !== 2'd0 || res_par !== want_par || res_err !== want_err) begin
      failures++;
      $display("FAIL %s_result: id=%0d par=%b err=%b want id=0 par=%b err=%b", nm, res_id,
               res_par, res_err, want_par, want_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fairness();
    logic [N-1:0] rdy;
    int tg, prev;
    bit ok;
    req_valid = 4'b1111;
    req_data  = {$urandom};
    res_ready = 1'b1;
    do_reset();
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      wait_grant(20, rdy, tg);
      checks++;
      if (rdy !== onehot(exp_winner(req_valid, rr))) begin
        failures++;
        $display("FAIL fair_order%0d: got %b want %b", i, rdy, onehot(exp_winner(req_valid, rr)));
      end
      rr = (exp_winner(req_valid, rr) + 1) % N;
      if (i > 0) begin
        checks++;
        if (tg - prev != W / 2 + 2) begin
          failures++;
          $display("FAIL fair_spacing%0d: got %0d want %0d", i, tg - prev, W / 2 + 2);
        end
      end
      prev = tg;
      @(posedge clk);
      #1;
    end
    drain(ok);
  endtask

  task automatic test_backpressure();
    logic [N-1:0] rdy;
    int tg, tr, rc, ew;
    logic ep, ee;
    bit ok;
    res_ready = 1'b0;
    req_data  = {$urandom};
    req_par   = N'($urandom);
    odd_mode  = 1'($urandom);
    req_valid = 4'b0010;
    ew = exp_winner(req_valid, rr);
    wait_grant(20, rdy, tg);
    checks++;
    if (rdy !== onehot(ew)) begin
      failures++;
      $display("FAIL bp_grant: got %b want %b", rdy, onehot(ew));
    end
    ep = exp_par(req_data[ew*W +: W], odd_mode);
    ee = ep ^ req_par[ew];
    rr = (ew + 1) % N;
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    wait_result(20, tr);
    checks++;
    if (tr != tg + LAT) begin
      failures++;
      $display("FAIL bp_latency: got cycle %0d want %0d", tr, tg + LAT);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      req_data = {$urandom};
      odd_mode = ~odd_mode;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_id !== IW'(ew) || res_par !== ep || res_err !== ee ||
          req_ready !== '0) begin
        failures++;
        $display("FAIL bp_hold%0d: v=%b id=%0d par=%b err=%b rdy=%b want 1 %0d %b %b 0000",
                 i, res_valid, res_id, res_par, res_err, req_ready, ew, ep, ee);
      end
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    rc = cyc;
    ew = exp_winner(req_valid, rr);
    wait_grant(20, rdy, tg);
    checks++;
    if (tg != rc + 1 || rdy !== onehot(ew)) begin
      failures++;
      $display("FAIL bp_regrant: cycle %0d rdy %b want cycle %0d rdy %b", tg, rdy, rc + 1,
               onehot(ew));
    end
    rr = (ew + 1) % N;
    @(posedge clk);
    #1;
    drain(ok);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] rdy;
    int tg, tr, rc;
    bit ok;
    res_ready = 1'b1;
    req_data  = {$urandom};
    req_valid = 4'b0001;
    wait_grant(20, rdy, tg);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rr  = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || res_valid !== 1'b0 || busy !== 1'b0 || res_par !== 1'b0 ||
        res_err !== 1'b0 || res_id !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: rdy=%b v=%b busy=%b par=%b err=%b id=%0d want all 0",
               req_ready, res_valid, busy, res_par, res_err, res_id);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rc  = cyc;
    wait_grant(20, rdy, tg);
    checks++;
    if (tg != rc || rdy !== onehot(exp_winner(req_valid, rr))) begin
      failures++;
      $display("FAIL midrst_regrant: cycle %0d rdy %b want cycle %0d rdy 0001", tg, rdy, rc);
    end
    rr = 1;
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_result(20, tr);
    checks++;
    if (tr != tg + LAT) begin
      failures++;
      $display("FAIL midrst_no_stale: first result cycle %0d want %0d", tr, tg + LAT);
    end
    @(posedge clk);
    #1;
    drain(ok);
  endtask

  task automatic test_random();
    logic [N-1:0] rdy, m;
    int tg, tr, ew, d;
    logic ep, ee;
    for (int it = 0; it < 40; it++) begin
      m = N'($urandom_range(1, 15));
      req_valid = m;
      req_data  = {$urandom};
      req_par   = N'($urandom);
      odd_mode  = 1'($urandom);
      res_ready = 1'b0;
      ew = exp_winner(m, rr);
      wait_grant(20, rdy, tg);
      checks++;
      if (rdy !== onehot(ew)) begin
        failures++;
        $display("FAIL rand%0d_grant: got %b want %b mask %b", it, rdy, onehot(ew), m);
      end
      ep = exp_par(req_data[ew*W +: W], odd_mode);
      ee = ep ^ req_par[ew];
      rr = (ew + 1) % N;
      @(posedge clk);
      #1;
      // Changing the request side after acceptance must not affect the result.
      req_data  = {$urandom};
      req_par   = N'($urandom);
      odd_mode  = 1'($urandom);
      req_valid = N'($urandom);
      wait_result(20, tr);
      checks++;
      if (tr != tg + LAT || res_id !== IW'(ew) || res_par !== ep || res_err !== ee) begin
        failures++;
        $display("FAIL rand%0d_result: cyc %0d id %0d par %b err %b want cyc %0d id %0d par %b err %b",
                 it, tr, res_id, res_par, res_err, tg + LAT, ew, ep, ee);
      end
      d = $urandom_range(0, 3);
      repeat (d) @(posedge clk);
      #1;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

`ifdef PARITY_ERR_CNT_EN
  task automatic send_words(input int n, input bit bad);
    logic [N-1:0] rdy;
    int tg;
    logic [W-1:0] d;
    req_valid = 4'b0001;
    res_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      d = W'($urandom);
      odd_mode = 1'($urandom);
      req_data = {24'h0, d};
      req_par  = {3'b000, exp_par(d, odd_mode) ^ logic'(bad)};
      wait_grant(20, rdy, tg);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_err_count();
    bit ok;
    do_reset();
    send_words(100, 1);
    drain(ok);
    checks++;
    if (err_count !== EW'(100)) begin
      failures++;
      $display("FAIL errcnt_100: got %0d want 100", err_count);
    end
    send_words(200, 1);
    drain(ok);
    checks++;
    if (err_count !== EW'((1 << EW) - 1)) begin
      failures++;
      $display("FAIL errcnt_sat: got %0d want %0d", err_count, (1 << EW) - 1);
    end
    do_reset();
    send_words(3, 1);
    send_words(1, 0);
    drain(ok);
    checks++;
    if (err_count !== EW'(3)) begin
      failures++;
      $display("FAIL errcnt_noerr: got %0d want 3", err_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "basic_even");
    test_basic(8'h07, 1'b0, 1'b0, 1'b1, 1'b1, "err_even");
    test_basic(8'h07, 1'b0, 1'b1, 1'b0, 1'b0, "odd_mode");
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef PARITY_ERR_CNT_EN
    test_err_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
